// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared funct3 codes, FSM states and operand-sign helpers for the RV32M multiply/divide unit
package muldiv_unit_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam int ITERS = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
  function automatic logic signed_a(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM;
  endfunction
  function automatic logic signed_b(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle (start, funct3, rs1, rs2 in; busy, done, result out)
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, rs1, rs2, input busy, done, result);
  modport slave  (input start, funct3, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle RV32M multiply/divide on magnitudes with sign fix-up; ports clk, reset, bus (slave)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  state_t state, state_n;
  logic [2:0] f3;
  logic sa, sb, st_sa, st_sb, is_mul, done_q;
  logic [5:0] cnt;
  logic [XLEN-1:0] b, quo, rem, fix_val, result_q;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN:0] x, y;
  logic [XLEN+1:0] sum;
  assign is_mul = !f3[2];
  assign st_sa = signed_a(bus.funct3) & bus.rs1[XLEN-1];
  assign st_sb = signed_b(bus.funct3) & bus.rs2[XLEN-1];
  // one adder: multiply adds b to the upper half, divide subtracts b from the shifted remainder (carry out = no borrow)
  assign x = is_mul ? {1'b0, acc[2*XLEN-1:XLEN]} : acc[2*XLEN-1:XLEN-1];
  assign y = is_mul ? {1'b0, b} : ~{1'b0, b};
  assign sum = {1'b0, x} + {1'b0, y} + {{(XLEN+1){1'b0}}, !is_mul};
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  // divide-by-zero remainder and signed overflow fall out of the magnitude datapath; only the zero-divisor quotient needs forcing
  assign fix_val = is_mul ? (f3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                 : f3[1] ? rem : (b == '0 ? '1 : quo);
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.result = result_q;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? RUN : IDLE)
            : state == RUN ? (cnt == 6'(ITERS - 1) ? FIX : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      f3 <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      b <= '0;
      acc <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= state == FIX;
      if (state == IDLE && bus.start) begin
        f3 <= bus.funct3;
        sa <= st_sa;
        sb <= st_sb;
        b <= st_sb ? -bus.rs2 : bus.rs2;
        acc <= {{XLEN{1'b0}}, st_sa ? -bus.rs1 : bus.rs1};
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
        acc <= is_mul ? (acc[0] ? {sum[XLEN:0], acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]})
             : (sum[XLEN+1] ? {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0});
      end
      if (state == FIX) result_q <= fix_val;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench with directed RV32M vectors, timing, ignored-start and mid-operation reset checks
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  typedef struct {logic [2:0] f3; logic [31:0] a, b, exp;} vec_t;
  typedef struct {logic [31:0] val; longint due;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_issued = 0;
  exp_t sb[$];
  vec_t vecs[16];
  muldiv_unit_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) begin
      n_done++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.val);
        check("done_time", $time, e.due);
      end
    end
  end
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit expect_done);
    bus.start = 1'b1;
    bus.funct3 = f3;
    bus.rs1 = a;
    bus.rs2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.funct3 = 3'bx;
    bus.rs1 = 32'hdead_beef;
    bus.rs2 = 32'h0bad_f00d;
    if (expect_done) begin
      sb.push_back('{val: exp, due: $time + 330});
      n_issued++;
    end
  endtask
  task automatic wait_idle(input int exp_busy);
    int n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, exp_busy);
  endtask
  initial begin
    vecs = '{
      '{F3_MUL,    32'd7,        32'd6,        32'd42},
      '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000},
      '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
      '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
      '{F3_DIVU,   32'd100,      32'd7,        32'd14},
      '{F3_REMU,   32'd100,      32'd7,        32'd2},
      '{F3_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF},
      '{F3_REM,    32'h1234,     32'd0,        32'h1234},
      '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0},
      '{F3_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF},
      '{F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1},
      '{F3_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF},
      '{F3_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h1}
    };
    bus.start = 1'b0;
    bus.funct3 = 3'b0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    @(negedge clk);
    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_idle(33);
    end
    issue(F3_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
    repeat (9) @(negedge clk);
    issue(F3_MUL, 32'd100, 32'd100, 32'd0, 1'b0);
    wait_idle(23);
    repeat (3) @(negedge clk);
    issue(F3_DIV, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_done", bus.done, 0);
    repeat (40) @(negedge clk);
    issue(F3_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
    wait_idle(33);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
